// File: rtl/pll_reseq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
package pll_reseq_pkg;

    localparam int unsigned RELOCK_CNT_W = 8;
    localparam int unsigned STATE_W      = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_STAGGER   = 3'd3,
        ST_RUN       = 3'd4
    } reseq_state_t;

    // Larger of two cycle counts, used to size the shared counter.
    function automatic int unsigned cnt_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, debounces lock and releases
// sys_rst then cpu_rst; any lock loss re-asserts both core resets.
// Optional macro PLL_RESEQ_TIMEOUT_EN: re-pulse the PLL reset when lock
// does not arrive within TIMEOUT_CYCLES in WAIT_LOCK.
module pll_reset_seq
    import pll_reseq_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned STAGGER_CYCLES = 8,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    locked,
    output logic                    pll_rst,
    output logic                    sys_rst,
    output logic                    cpu_rst,
    output logic                    ready,
    output logic [RELOCK_CNT_W-1:0] relock_cnt
);

    localparam int unsigned CNT_BASE = cnt_max(cnt_max(STABLE_CYCLES, PLL_RST_CYCLES),
                                               STAGGER_CYCLES);
`ifdef PLL_RESEQ_TIMEOUT_EN
    localparam int unsigned CNT_MAX  = cnt_max(CNT_BASE, TIMEOUT_CYCLES);
`else
    localparam int unsigned CNT_MAX  = CNT_BASE;
`endif
    localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Reject parameter values the sequencing cannot honour.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 2");
    end
    if (PLL_RST_CYCLES < 1) begin : g_bad_pll_rst
        $error("PLL_RST_CYCLES must be at least 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_bad_stagger
        $error("STAGGER_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic                    locked_s;
    reseq_state_t            state_q,   state_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic                    pll_rst_q, pll_rst_d;
    logic                    sys_rst_q, sys_rst_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    ready_q,   ready_d;
    logic [RELOCK_CNT_W-1:0] relock_q,  relock_d;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (locked),
        .q_o (locked_s)
    );

    // State, shared counter and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            cpu_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            relock_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            cpu_rst_q <= cpu_rst_d;
            ready_q   <= ready_d;
            relock_q  <= relock_d;
        end
    end

    // Next-state and next-output logic; lock loss always wins over counting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pll_rst_d = pll_rst_q;
        sys_rst_d = sys_rst_q;
        cpu_rst_d = cpu_rst_q;
        ready_d   = ready_q;
        relock_d  = relock_q;

        case (state_q)
            ST_PLL_RST: begin
                pll_rst_d = 1'b1;
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_d   = ST_WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
`ifdef PLL_RESEQ_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = ST_PLL_RST;
                        cnt_d     = '0;
                        pll_rst_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    cnt_d = '0;
`endif
                end
            end

            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d   = ST_STAGGER;
                    cnt_d     = '0;
                    sys_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STAGGER: begin
                if (!locked_s) begin
                    state_d   = ST_WAIT_LOCK;
                    cnt_d     = '0;
                    sys_rst_d = 1'b1;
                    cpu_rst_d = 1'b1;
                    ready_d   = 1'b0;
                    if (relock_q != '1) begin
                        relock_d = relock_q + RELOCK_CNT_W'(1);
                    end
                end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    cpu_rst_d = 1'b0;
                    ready_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (!locked_s) begin
                    state_d   = ST_WAIT_LOCK;
                    cnt_d     = '0;
                    sys_rst_d = 1'b1;
                    cpu_rst_d = 1'b1;
                    ready_d   = 1'b0;
                    if (relock_q != '1) begin
                        relock_d = relock_q + RELOCK_CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d   = ST_PLL_RST;
                cnt_d     = '0;
                pll_rst_d = 1'b1;
                sys_rst_d = 1'b1;
                cpu_rst_d = 1'b1;
                ready_d   = 1'b0;
            end
        endcase
    end

    assign pll_rst    = pll_rst_q;
    assign sys_rst    = sys_rst_q;
    assign cpu_rst    = cpu_rst_q;
    assign ready      = ready_q;
    assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with STABLE=8, PLL_RST=4, STAGGER=3, TIMEOUT=20.
module tb_pll_reset_seq;

    logic       refclk;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       cpu_rst;
    logic       ready;
    logic [7:0] relock_cnt;

    int checks   = 0;
    int failures = 0;
    bit tmo_en;

    pll_reset_seq #(
        .STABLE_CYCLES  (8),
        .PLL_RST_CYCLES (4),
        .STAGGER_CYCLES (3),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .cpu_rst    (cpu_rst),
        .ready      (ready),
        .relock_cnt (relock_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic p, input logic s,
                            input logic c, input logic r);
        chk({tag, ".pll_rst"}, 8'(pll_rst), 8'(p));
        chk({tag, ".sys_rst"}, 8'(sys_rst), 8'(s));
        chk({tag, ".cpu_rst"}, 8'(cpu_rst), 8'(c));
        chk({tag, ".ready"},   8'(ready),   8'(r));
    endtask

    // locked has just been raised; edge 1 samples it. sys_rst falls at 11, cpu_rst/ready at 14.
    task automatic run_release(input string tag);
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk_outs($sformatf("%s.e%0d", tag, e), 1'b0, (e < 11), (e < 14), (e >= 14));
        end
    endtask

    // Drop lock from RUN/STAGGER: resets return high two edges after the first sampling edge.
    task automatic lose_lock(input string tag, input logic [7:0] exp_relock);
        locked = 1'b0;
        tick();
        chk({tag, ".e1.sys_rst"}, 8'(sys_rst), 8'd0);
        tick();
        chk({tag, ".e2.sys_rst"}, 8'(sys_rst), 8'd0);
        tick();
        chk_outs({tag, ".e3"}, 1'b0, 1'b1, 1'b1, 1'b0);
        chk({tag, ".relock"}, relock_cnt, exp_relock);
    endtask

    initial begin
`ifdef PLL_RESEQ_TIMEOUT_EN
        tmo_en = 1'b1;
`else
        tmo_en = 1'b0;
`endif
        rst    = 1'b1;
        locked = 1'b0;
        repeat (2) tick();
        chk_outs("reset", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("reset.relock", relock_cnt, 8'd0);

        // Release rst with locked low for 60 edges: first pll_rst pulse is 4 edges wide.
        rst = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            chk_outs($sformatf("nolock.e%0d", n),
                     (n < 4) || (tmo_en && (n >= 24) && ((n % 24) < 4)),
                     1'b1, 1'b1, 1'b0);
        end

        // First lock acquisition.
        locked = 1'b1;
        run_release("lock1");
        chk("lock1.relock", relock_cnt, 8'd0);

        // Loss in RUN, then relock.
        lose_lock("loss1", 8'd1);
        locked = 1'b1;
        run_release("lock2");

        // Loss, relock, and a 3-cycle dropout at STABLE count 5.
        lose_lock("loss2", 8'd2);
        locked = 1'b1;
        repeat (8) tick();
        locked = 1'b0;
        for (int g = 9; g <= 11; g++) begin
            tick();
            chk_outs($sformatf("glitch.e%0d", g), 1'b0, 1'b1, 1'b1, 1'b0);
        end
        locked = 1'b1;
        run_release("lock3");
        chk("lock3.relock", relock_cnt, 8'd2);

        // Drive the loss counter into saturation.
        for (int i = 0; i < 254; i++) begin
            locked = 1'b0;
            repeat (3) tick();
            chk($sformatf("sat.relock%0d", i), relock_cnt, ((3 + i) > 255) ? 8'd255 : 8'(3 + i));
            locked = 1'b1;
            repeat (14) tick();
        end
        chk_outs("sat.run", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reach STAGGER, then abort with rst between clock edges.
        lose_lock("loss3", 8'd255);
        locked = 1'b1;
        repeat (11) tick();
        chk_outs("stagger", 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        rst    = 1'b1;
        locked = 1'b0;
        #1;
        chk_outs("async_rst", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("async_rst.relock", relock_cnt, 8'd0);
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            chk_outs($sformatf("rerun.e%0d", n), (n < 4), 1'b1, 1'b1, 1'b0);
        end
        locked = 1'b1;
        run_release("lock4");
        chk("lock4.relock", relock_cnt, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
